attitude_packet_parser: RTL and testbench
=========================================

Name: attitude_packet_parser

Overview:
Consumes the received-byte stream of the UART receiver (data-valid pulse plus byte) and extracts fixed-format attitude frames sent by the host PC. It validates sync, payload and checksum, then presents registered signed pitch and roll words to the attitude-indicator rendering logic. It is the stage directly downstream of the UART receive path, on the same 25 MHz clock.

Parameters:
TIMEOUT_CLKS, 8680, max clocks allowed between consecutive bytes inside a frame (about 4 byte-times at 115200 baud, 25 MHz)
SYNC0, 8'hAA, first sync byte
SYNC1, 8'h55, second sync byte

Ports:
i_Clk  input  1  system clock (25 MHz)
i_Rst  input  1  asynchronous, active-high reset
i_rx_dv  input  1  received-byte valid, one-clock pulse from the UART receiver
i_rx_byte  input  8  received byte, valid when i_rx_dv=1
o_pitch  output  16  signed pitch, last good frame, two's complement
o_roll  output  16  signed roll, last good frame, two's complement
o_valid  output  1  one-clock pulse when o_pitch/o_roll update
o_err  output  1  one-clock pulse on checksum mismatch or inter-byte timeout
o_busy  output  1  high while a frame is partially received (state != IDLE)

Behaviour:
- Reset: one clock, asynchronous active-high reset. Async assert, all state cleared. o_pitch=0, o_roll=0, o_valid=0, o_err=0, o_busy=0, FSM=IDLE, counters=0.
- Frame format, 7 bytes: SYNC0, SYNC1, pitch_hi, pitch_lo, roll_hi, roll_lo, chk.
- chk = 8-bit sum modulo 256 of the four payload bytes.
- All state changes occur only on cycles where i_rx_dv=1, except the timeout path.
- FSM states:
  - IDLE: on byte == SYNC0 go to SYNC; any other byte is ignored.
  - SYNC: on SYNC1 go to PAYLOAD with idx=0 and sum=0. On SYNC0 stay in SYNC (resync on repeated 0xAA). On any other byte go to IDLE with no error pulse.
  - PAYLOAD: shift the byte into a 32-bit payload register, sum += byte (8-bit wrap), idx += 1. After idx reaches 3 (the 4th byte), go to CHECK. Payload bytes are not compared against sync values.
  - CHECK: on the next byte, compare it to sum. On match, load o_pitch={p_hi,p_lo} and o_roll={r_hi,r_lo} and pulse o_valid. On mismatch, pulse o_err and leave outputs unchanged. Go to IDLE in both cases.
- Latency: o_valid/o_err assert on the clock edge after the cycle in which the checksum byte's i_rx_dv=1. o_pitch/o_roll update on that same edge.
- Outputs are always registered, and o_valid never asserts with stale data.
- Timeout counter: cleared on every i_rx_dv and whenever in IDLE; otherwise increments while in SYNC, PAYLOAD or CHECK. When it reaches TIMEOUT_CLKS-1 with no i_rx_dv in that cycle, go to IDLE and pulse o_err for one clock.
  - If i_rx_dv coincides with the terminal count, the byte wins and no timeout occurs.
  - Counter width is $clog2(TIMEOUT_CLKS), saturating behaviour not required.
- A complete frame may start on the very next byte after chk; no idle gap is needed.
- o_busy = (state != IDLE), registered.
- o_valid and o_err are mutually exclusive and never high two consecutive cycles for one frame.
- Reset mid-frame: the partial frame is discarded and the last good outputs are cleared to 0.

Optional Feature:
Macro ATTITUDE_PARSER_ERRCNT_EN.
- Defined: adds output port o_err_count[7:0]. It increments by 1 on each o_err pulse, saturates at 255, and resets to 0 on i_Rst.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Good frame: bytes AA 55 01 2C FF 9C C8 -> single o_valid pulse one clock after the C8 dv, o_pitch=16'h012C (300), o_roll=16'hFF9C (-100), o_err stays 0.
- Bad checksum: AA 55 01 2C FF 9C C9 -> single o_err pulse, o_valid=0, outputs hold previous values; with ATTITUDE_PARSER_ERRCNT_EN defined, o_err_count = 1.
- Resync/garbage: 13 AA AA 55 00 0A 00 14 1E -> o_valid, o_pitch=10, o_roll=20; AA 12 ... -> back to IDLE with no o_err.
- Timeout: AA 55 01, then no bytes for TIMEOUT_CLKS clocks -> o_err pulse at terminal count, o_busy falls; a following full good frame parses correctly. Also drive a byte exactly at the terminal count -> no timeout.
- Back-to-back frames at full baud (frame A, then frame B immediately) -> two o_valid pulses, final outputs equal to frame B.
- Async reset asserted after 3 payload bytes -> outputs 0 and o_busy=0 immediately. After release, the remaining stale bytes plus chk produce no o_valid.

Source files
------------

// File: rtl/attitude_packet_parser.sv
// -----------------------------------------------------------------------------
// attitude_packet_parser
//
// Extracts 7-byte attitude frames from the UART receive byte stream:
//     SYNC0, SYNC1, pitch_hi, pitch_lo, roll_hi, roll_lo, chk
// where chk is the 8-bit wrapping sum of the four payload bytes. A frame whose
// checksum matches loads the registered signed pitch/roll words and pulses
// o_valid. A bad checksum, or a gap between bytes longer than TIMEOUT_CLKS
// clocks inside a frame, pulses o_err and drops the partial frame.
//
// Ports:
//     i_Clk        system clock (25 MHz)
//     i_Rst        asynchronous active-high reset
//     i_rx_dv      one-clock received-byte strobe from the UART receiver
//     i_rx_byte    received byte, valid while i_rx_dv = 1
//     o_pitch      signed pitch from the last good frame
//     o_roll       signed roll from the last good frame
//     o_valid      one-clock pulse when o_pitch/o_roll update
//     o_err        one-clock pulse on checksum mismatch or inter-byte timeout
//     o_busy       high while a frame is partially received
//     o_err_count  saturating count of o_err pulses
//                  (only when ATTITUDE_PARSER_ERRCNT_EN is defined)
//
// Build option:
//     ATTITUDE_PARSER_ERRCNT_EN  adds the o_err_count port and its counter.
// -----------------------------------------------------------------------------
module attitude_packet_parser #(
    parameter int          TIMEOUT_CLKS = 8680,
    parameter logic [7:0]  SYNC0        = 8'hAA,
    parameter logic [7:0]  SYNC1        = 8'h55
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_rx_dv,
    input  logic [7:0]  i_rx_byte,
    output logic [15:0] o_pitch,
    output logic [15:0] o_roll,
    output logic        o_valid,
    output logic        o_err,
    output logic        o_busy
`ifdef ATTITUDE_PARSER_ERRCNT_EN
    ,
    output logic [7:0]  o_err_count
`endif
);

    localparam int                TMO_W    = $clog2(TIMEOUT_CLKS);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } state_t;

    state_t             r_state;
    logic [1:0]         r_idx;
    logic [7:0]         r_sum;
    logic [31:0]        r_payload;
    logic [TMO_W-1:0]   r_tmo;

    state_t             w_state_nxt;
    logic [1:0]         w_idx_nxt;
    logic [7:0]         w_sum_nxt;
    logic [31:0]        w_payload_nxt;
    logic [TMO_W-1:0]   w_tmo_nxt;
    logic [15:0]        w_pitch_nxt;
    logic [15:0]        w_roll_nxt;
    logic               w_valid_nxt;
    logic               w_err_nxt;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_sum     <= '0;
            r_payload <= '0;
            r_tmo     <= '0;
            o_pitch   <= '0;
            o_roll    <= '0;
            o_valid   <= 1'b0;
            o_err     <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_sum     <= w_sum_nxt;
            r_payload <= w_payload_nxt;
            r_tmo     <= w_tmo_nxt;
            o_pitch   <= w_pitch_nxt;
            o_roll    <= w_roll_nxt;
            o_valid   <= w_valid_nxt;
            o_err     <= w_err_nxt;
            o_busy    <= (w_state_nxt != IDLE);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_sum_nxt     = r_sum;
        w_payload_nxt = r_payload;
        w_pitch_nxt   = o_pitch;
        w_roll_nxt    = o_roll;
        w_valid_nxt   = 1'b0;
        w_err_nxt     = 1'b0;

        // The inter-byte timer only runs while a frame is in progress.
        if (r_state == IDLE || i_rx_dv) begin
            w_tmo_nxt = '0;
        end else begin
            w_tmo_nxt = r_tmo + 1'b1;
        end

        if (i_rx_dv) begin
            case (r_state)
                IDLE: begin
                    if (i_rx_byte == SYNC0) begin
                        w_state_nxt = SYNC;
                    end
                end
                SYNC: begin
                    // A repeated SYNC0 keeps us aligned on the newest one.
                    if (i_rx_byte == SYNC1) begin
                        w_state_nxt = PAYLOAD;
                        w_idx_nxt   = '0;
                        w_sum_nxt   = '0;
                    end else if (i_rx_byte != SYNC0) begin
                        w_state_nxt = IDLE;
                    end
                end
                PAYLOAD: begin
                    w_payload_nxt = {r_payload[23:0], i_rx_byte};
                    w_sum_nxt     = r_sum + i_rx_byte;
                    w_idx_nxt     = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    if (i_rx_byte == r_sum) begin
                        w_pitch_nxt = r_payload[31:16];
                        w_roll_nxt  = r_payload[15:0];
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end else if (r_state != IDLE && r_tmo == TMO_LAST) begin
            // A byte arriving on the terminal count takes the branch above,
            // so the timeout only fires on a silent terminal cycle.
            w_state_nxt = IDLE;
            w_err_nxt   = 1'b1;
        end
    end

`ifdef ATTITUDE_PARSER_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_err_count <= '0;
        end else if (w_err_nxt && r_err_count != 8'hFF) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign o_err_count = r_err_count;
`endif

endmodule

// File: tb/tb_attitude_packet_parser.sv
// -----------------------------------------------------------------------------
// tb_attitude_packet_parser
//
// Directed bench for attitude_packet_parser. Bytes are presented one clock
// each; outputs are sampled 1 ns after the rising edge that consumed a byte.
// The timeout is shortened to TMO clocks so boundary cycles can be counted.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_attitude_packet_parser;

    localparam int TMO = 64;

    logic        i_Clk;
    logic        i_Rst;
    logic        i_rx_dv;
    logic [7:0]  i_rx_byte;
    logic [15:0] o_pitch;
    logic [15:0] o_roll;
    logic        o_valid;
    logic        o_err;
    logic        o_busy;
`ifdef ATTITUDE_PARSER_ERRCNT_EN
    logic [7:0]  o_err_count;
`endif

    int checks = 0;
    int errors = 0;
    int validPulses = 0;
    int errPulses = 0;
    int vSnap;
    int eSnap;

    attitude_packet_parser #(
        .TIMEOUT_CLKS (TMO),
        .SYNC0        (8'hAA),
        .SYNC1        (8'h55)
    ) dut (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_rx_dv   (i_rx_dv),
        .i_rx_byte (i_rx_byte),
        .o_pitch   (o_pitch),
        .o_roll    (o_roll),
        .o_valid   (o_valid),
        .o_err     (o_err),
        .o_busy    (o_busy)
`ifdef ATTITUDE_PARSER_ERRCNT_EN
        ,
        .o_err_count (o_err_count)
`endif
    );

    // 25 MHz
    initial i_Clk = 1'b0;
    always #20 i_Clk = ~i_Clk;

    // Each registered pulse is high for exactly one edge-to-edge interval.
    always @(posedge i_Clk) begin
        if (o_valid === 1'b1) validPulses++;
        if (o_err === 1'b1) errPulses++;
    end

    // Present one byte for one clock; returns 1 ns after the consuming edge.
    task automatic applyStimulus(input logic [7:0] b);
        i_rx_dv   = 1'b1;
        i_rx_byte = b;
        @(posedge i_Clk);
        #1;
        i_rx_dv   = 1'b0;
    endtask

    task automatic idleClocks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_Clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        i_Rst     = 1'b1;
        i_rx_dv   = 1'b0;
        i_rx_byte = 8'h00;
        idleClocks(3);
        checkOutput("rst_pitch", 32'(o_pitch), 32'h0);
        checkOutput("rst_roll",  32'(o_roll),  32'h0);
        checkOutput("rst_valid", 32'(o_valid), 32'h0);
        checkOutput("rst_err",   32'(o_err),   32'h0);
        checkOutput("rst_busy",  32'(o_busy),  32'h0);
        i_Rst = 1'b0;
        idleClocks(2);

        $display("[TB] good frame");
        applyStimulus(8'hAA);
        checkOutput("good_busy_after_sync0", 32'(o_busy), 32'h1);
        applyStimulus(8'h55);
        applyStimulus(8'h01);
        applyStimulus(8'h2C);
        applyStimulus(8'hFF);
        applyStimulus(8'h9C);
        checkOutput("good_valid_before_chk", 32'(o_valid), 32'h0);
        applyStimulus(8'hC8);
        checkOutput("good_valid", 32'(o_valid), 32'h1);
        checkOutput("good_err",   32'(o_err),   32'h0);
        checkOutput("good_pitch", 32'(o_pitch), 32'h012C);
        checkOutput("good_roll",  32'(o_roll),  32'hFF9C);
        checkOutput("good_busy_after", 32'(o_busy), 32'h0);
        idleClocks(1);
        checkOutput("good_valid_one_pulse", 32'(o_valid), 32'h0);

        $display("[TB] bad checksum");
        applyStimulus(8'hAA);
        applyStimulus(8'h55);
        applyStimulus(8'h01);
        applyStimulus(8'h2C);
        applyStimulus(8'hFF);
        applyStimulus(8'h9C);
        applyStimulus(8'hC9);
        checkOutput("bad_err",   32'(o_err),   32'h1);
        checkOutput("bad_valid", 32'(o_valid), 32'h0);
        checkOutput("bad_pitch_hold", 32'(o_pitch), 32'h012C);
        checkOutput("bad_roll_hold",  32'(o_roll),  32'hFF9C);
`ifdef ATTITUDE_PARSER_ERRCNT_EN
        checkOutput("bad_err_count", 32'(o_err_count), 32'h1);
`endif
        idleClocks(1);
        checkOutput("bad_err_one_pulse", 32'(o_err), 32'h0);

        $display("[TB] resync and garbage");
        applyStimulus(8'h13);
        checkOutput("garbage_busy", 32'(o_busy), 32'h0);
        applyStimulus(8'hAA);
        applyStimulus(8'hAA);
        checkOutput("resync_busy", 32'(o_busy), 32'h1);
        applyStimulus(8'h55);
        applyStimulus(8'h00);
        applyStimulus(8'h0A);
        applyStimulus(8'h00);
        applyStimulus(8'h14);
        applyStimulus(8'h1E);
        checkOutput("resync_valid", 32'(o_valid), 32'h1);
        checkOutput("resync_pitch", 32'(o_pitch), 32'h000A);
        checkOutput("resync_roll",  32'(o_roll),  32'h0014);
        eSnap = errPulses;
        applyStimulus(8'hAA);
        applyStimulus(8'h12);
        checkOutput("abort_busy", 32'(o_busy), 32'h0);
        checkOutput("abort_err",  32'(o_err),  32'h0);
        idleClocks(2);
        checkOutput("abort_no_err_pulse", 32'(errPulses - eSnap), 32'h0);

        $display("[TB] inter-byte timeout");
        applyStimulus(8'hAA);
        applyStimulus(8'h55);
        applyStimulus(8'h01);
        idleClocks(TMO - 1);
        checkOutput("tmo_not_yet_err",  32'(o_err),  32'h0);
        checkOutput("tmo_not_yet_busy", 32'(o_busy), 32'h1);
        idleClocks(1);
        checkOutput("tmo_err",  32'(o_err),  32'h1);
        checkOutput("tmo_busy", 32'(o_busy), 32'h0);
        idleClocks(1);
        checkOutput("tmo_err_one_pulse", 32'(o_err), 32'h0);
        applyStimulus(8'hAA);
        applyStimulus(8'h55);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        applyStimulus(8'h56);
        applyStimulus(8'h78);
        applyStimulus(8'h14);
        checkOutput("post_tmo_valid", 32'(o_valid), 32'h1);
        checkOutput("post_tmo_pitch", 32'(o_pitch), 32'h1234);
        checkOutput("post_tmo_roll",  32'(o_roll),  32'h5678);

        $display("[TB] byte on terminal count");
        eSnap = errPulses;
        applyStimulus(8'hAA);
        applyStimulus(8'h55);
        idleClocks(TMO - 1);
        applyStimulus(8'h00);
        checkOutput("term_err",  32'(o_err),  32'h0);
        checkOutput("term_busy", 32'(o_busy), 32'h1);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        checkOutput("term_valid", 32'(o_valid), 32'h1);
        checkOutput("term_pitch", 32'(o_pitch), 32'h0001);
        checkOutput("term_roll",  32'(o_roll),  32'h0002);
        checkOutput("term_no_err_pulse", 32'(errPulses - eSnap), 32'h0);

        $display("[TB] back-to-back frames");
        idleClocks(1);
        vSnap = validPulses;
        applyStimulus(8'hAA);
        applyStimulus(8'h55);
        applyStimulus(8'h00);
        applyStimulus(8'h64);
        applyStimulus(8'h00);
        applyStimulus(8'hC8);
        applyStimulus(8'h2C);
        checkOutput("b2b_a_valid", 32'(o_valid), 32'h1);
        checkOutput("b2b_a_pitch", 32'(o_pitch), 32'h0064);
        checkOutput("b2b_a_roll",  32'(o_roll),  32'h00C8);
        applyStimulus(8'hAA);
        applyStimulus(8'h55);
        applyStimulus(8'hFF);
        applyStimulus(8'h38);
        applyStimulus(8'h00);
        applyStimulus(8'h32);
        applyStimulus(8'h69);
        checkOutput("b2b_b_valid", 32'(o_valid), 32'h1);
        checkOutput("b2b_b_pitch", 32'(o_pitch), 32'hFF38);
        checkOutput("b2b_b_roll",  32'(o_roll),  32'h0032);
        idleClocks(2);
        checkOutput("b2b_valid_count", 32'(validPulses - vSnap), 32'h2);

        $display("[TB] reset mid-frame");
        applyStimulus(8'hAA);
        applyStimulus(8'h55);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        i_Rst = 1'b1;
        #1;
        checkOutput("midrst_pitch", 32'(o_pitch), 32'h0);
        checkOutput("midrst_roll",  32'(o_roll),  32'h0);
        checkOutput("midrst_busy",  32'(o_busy),  32'h0);
        idleClocks(2);
        i_Rst = 1'b0;
        idleClocks(1);
        vSnap = validPulses;
        applyStimulus(8'h04);
        applyStimulus(8'h0A);
        checkOutput("midrst_no_valid", 32'(o_valid), 32'h0);
        checkOutput("midrst_busy_after", 32'(o_busy), 32'h0);
        idleClocks(2);
        checkOutput("midrst_valid_count", 32'(validPulses - vSnap), 32'h0);
        checkOutput("midrst_pitch_after", 32'(o_pitch), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
